// File: rtl/fact_controller.sv
// Moore FSM sequencing fact_datapath through one factorial per go request,
// with abort, operand-range error and an iteration watchdog.
module fact_controller #(
    parameter int unsigned MAX_ITER = 15,
    parameter int unsigned ITER_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       abort,
    input  logic       cnt_out,
    input  logic       in_gt_12,
    output logic [5:0] control_signals,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] state_dbg
);

    localparam int unsigned STATE_W = 3;
    localparam int unsigned CTRL_W  = 6;

    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_LOAD  = 3'd1;
    localparam logic [STATE_W-1:0] S_CHECK = 3'd2;
    localparam logic [STATE_W-1:0] S_MULT  = 3'd3;
    localparam logic [STATE_W-1:0] S_DONE  = 3'd4;
    localparam logic [STATE_W-1:0] S_ERR   = 3'd5;

    localparam logic [CTRL_W-1:0] CTRL_IDLE = 6'b000000;
    localparam logic [CTRL_W-1:0] CTRL_LOAD = 6'b100101;
    localparam logic [CTRL_W-1:0] CTRL_MULT = 6'b110001;
    localparam logic [CTRL_W-1:0] CTRL_DONE = 6'b001000;

    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);
    localparam logic [ITER_W-1:0] ITER_SAT   = {ITER_W{1'b1}};

    logic [STATE_W-1:0] state_q, state_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    // Next-state and watchdog counter; abort wins only in the active states.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        case (state_q)
            S_IDLE: begin
                if (go) state_d = in_gt_12 ? S_ERR : S_LOAD;
            end
            S_LOAD: begin
                iter_d  = '0;
                state_d = abort ? S_IDLE : S_CHECK;
            end
            S_CHECK: begin
                if (abort)                  state_d = S_IDLE;
                else if (cnt_out)           state_d = S_DONE;
                else if (iter_q == ITER_LIMIT) state_d = S_ERR;
                else                        state_d = S_MULT;
            end
            S_MULT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CHECK;
                    if (iter_q != ITER_SAT) iter_d = iter_q + ITER_W'(1);
                end
            end
            S_DONE:  state_d = go ? S_DONE : S_IDLE;
            S_ERR:   state_d = go ? S_ERR : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the next state so the registered copies track state_q.
    always_comb begin
        ctrl_d = CTRL_IDLE;
        busy_d = 1'b0;
        done_d = 1'b0;
        err_d  = 1'b0;
        case (state_d)
            S_LOAD:  begin ctrl_d = CTRL_LOAD; busy_d = 1'b1; end
            S_CHECK: busy_d = 1'b1;
            S_MULT:  begin ctrl_d = CTRL_MULT; busy_d = 1'b1; end
            S_DONE:  begin ctrl_d = CTRL_DONE; done_d = 1'b1; end
            S_ERR:   err_d = 1'b1;
            default: ctrl_d = CTRL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            ctrl_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            ctrl_q  <= ctrl_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign control_signals = ctrl_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_fact_controller.sv
// Bench for fact_controller: a small datapath model closes the loop, results
// are checked against factorial arithmetic and latency rules.
module tb_fact_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic        abort;
    logic        cnt_out;
    logic        in_gt_12;
    logic [5:0]  control_signals;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  state_dbg;

    logic [3:0]  in_val;
    logic        force_stuck;
    logic [3:0]  dp_cnt;
    logic [31:0] dp_d;
    logic [31:0] dp_result;

    int n_checks = 0;
    int n_fail   = 0;

    fact_controller #(.MAX_ITER(15), .ITER_W(4)) dut (
        .clk(clk), .rst(rst), .go(go), .abort(abort),
        .cnt_out(cnt_out), .in_gt_12(in_gt_12),
        .control_signals(control_signals), .busy(busy), .done(done),
        .err(err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Datapath stand-in driven by the control word {en_D,mux_s0,mux_s1,cnt_ld,cnt_ud,cnt_ce}.
    always @(posedge clk) begin
        if (control_signals[0]) begin
            if (control_signals[2])      dp_cnt <= in_val;
            else if (control_signals[1]) dp_cnt <= dp_cnt + 4'd1;
            else                         dp_cnt <= dp_cnt - 4'd1;
        end
        if (control_signals[5]) dp_d <= control_signals[4] ? dp_d * 32'(dp_cnt) : 32'd1;
    end
    assign dp_result = control_signals[3] ? dp_d : 32'd0;
    assign cnt_out   = force_stuck ? 1'b0 : (dp_cnt < 4'd2);
    assign in_gt_12  = (in_val > 4'd12);

    typedef struct {
        logic [3:0]  n;
        logic        hold;
        logic        exp_done;
        int          exp_edges;
        int          exp_mults;
        logic [31:0] exp_result;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: factorial, latency and multiply count from plain arithmetic.
    function automatic vec_t ref_run(input logic [3:0] n, input logic hold);
        vec_t v;
        int   k;
        v.n = n;
        v.hold = hold;
        if (n > 4'd12) begin
            v.exp_done = 1'b0; v.exp_edges = 1; v.exp_mults = 0; v.exp_result = 0;
        end else begin
            k = (n == 0) ? 1 : int'(n);
            v.exp_done   = 1'b1;
            v.exp_edges  = 2 * k + 1;
            v.exp_mults  = k - 1;
            v.exp_result = 1;
            for (int i = 2; i <= int'(n); i++) v.exp_result = v.exp_result * 32'(i);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request from IDLE through DONE/ERR back to IDLE, fully checked.
    task automatic run_vec(input vec_t v);
        int edges = 0;
        int mults = 0;
        int viol  = 0;
        in_val = v.n;
        go     = 1'b1;
        while (1) begin
            tick();
            edges++;
            if (!v.hold && edges == 1) go = 1'b0;
            if ((32'(busy) + 32'(done) + 32'(err)) > 1 || state_dbg > 3'd5) viol++;
            if (state_dbg == 3'd3) mults++;
            if (done || err || edges >= 100) break;
        end
        chk($sformatf("n%0d_edges", v.n), 32'(edges), 32'(v.exp_edges));
        chk($sformatf("n%0d_mults", v.n), 32'(mults), 32'(v.exp_mults));
        chk($sformatf("n%0d_done", v.n), 32'(done), 32'(v.exp_done));
        chk($sformatf("n%0d_err", v.n), 32'(err), 32'(!v.exp_done));
        chk($sformatf("n%0d_result", v.n), dp_result, v.exp_result);
        chk($sformatf("n%0d_ctrl", v.n), 32'(control_signals), v.exp_done ? 32'h08 : 32'h00);
        chk($sformatf("n%0d_exclusive", v.n), 32'(viol), 32'd0);
        if (v.hold) begin
            repeat (2) tick();
            chk($sformatf("n%0d_held", v.n), {30'd0, done, err}, v.exp_done ? 32'd2 : 32'd1);
            go = 1'b0;
        end
        tick();
        chk($sformatf("n%0d_idle", v.n), {28'd0, state_dbg, done | err}, 32'd0);
    endtask

    task automatic wait_state(input logic [2:0] s, input int nth, input string name);
        int seen = 0;
        for (int e = 0; e < 100; e++) begin
            tick();
            if (state_dbg == s) seen++;
            if (seen == nth) return;
        end
        chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{4'd3,  1'b1, 1'b1, 7,  2,  32'd6};
        tbl[1] = '{4'd0,  1'b1, 1'b1, 3,  0,  32'd1};
        tbl[2] = '{4'd1,  1'b0, 1'b1, 3,  0,  32'd1};
        tbl[3] = '{4'd12, 1'b1, 1'b1, 25, 11, 32'd479001600};
        tbl[4] = '{4'd13, 1'b1, 1'b0, 1,  0,  32'd0};
        tbl[5] = '{4'd7,  1'b0, 1'b1, 15, 6,  32'd5040};
        tbl[6] = '{4'd15, 1'b0, 1'b0, 1,  0,  32'd0};

        rst = 1'b0; go = 1'b0; abort = 1'b0; in_val = 4'd0; force_stuck = 1'b0;
        dp_cnt = 4'd0; dp_d = 32'd0;
        #3;
        chk("reset_outputs", {22'd0, control_signals, busy, done, err, state_dbg}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("post_reset_idle", {28'd0, state_dbg, busy}, 32'd0);

        foreach (tbl[i]) run_vec(tbl[i]);

        for (int r = 0; r < 20; r++)
            run_vec(ref_run(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1))));

        // Abort in the second MULT, then a fresh pulsed run.
        in_val = 4'd5; go = 1'b1;
        wait_state(3'd3, 2, "abort");
        abort = 1'b1; go = 1'b0;
        tick();
        abort = 1'b0;
        chk("abort_idle", {28'd0, state_dbg, busy}, 32'd0);
        chk("abort_no_done", 32'(done), 32'd0);
        run_vec(ref_run(4'd4, 1'b0));

        // Asynchronous reset between edges while in MULT.
        in_val = 4'd5; go = 1'b1;
        wait_state(3'd3, 1, "rst_mid");
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_outputs", {22'd0, control_signals, busy, done, err, state_dbg}, 32'd0);
        go = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("rst_mid_idle", 32'(state_dbg), 32'd0);

        // Stuck counter: watchdog trips after MAX_ITER multiplies.
        force_stuck = 1'b1;
        run_vec('{4'd5, 1'b1, 1'b0, 2 * 15 + 3, 15, 32'd0});
        force_stuck = 1'b0;
        run_vec(ref_run(4'd6, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
